// File: rtl/lms_fir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lms_fir_pkg                                                          |
// | Shared types, constants and helpers for the multi-channel LMS FIR.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package lms_fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  localparam int DRAIN_CYCLES = 4;

  function automatic int acc_width(input int dw, input int taps);
    return 2 * dw + $clog2(taps) + 1;
  endfunction

  function automatic int ch_bits(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  // Clamp a sign-extended value to the signed range of a w-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lms_fir_sat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lms_fir_sat                                                          |
// | Parametrised signed saturator, IN_W bits down to OUT_W bits.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lms_fir_sat
  import lms_fir_pkg::*;
#(
  parameter int IN_W  = 27,
  parameter int OUT_W = 26
) (
  input  logic signed [IN_W-1:0]  in_val,
  output logic signed [OUT_W-1:0] out_val
);

  logic signed [63:0] in_ext;

  assign in_ext  = 64'(in_val);
  assign out_val = OUT_W'(saturate(in_ext, OUT_W));

endmodule
`default_nettype wire

// File: rtl/lms_fir_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lms_fir_mc                                                           |
// | Multi-channel tap-serial LMS adaptive FIR (update, then MAC).        |
// | Optional weight leakage: define LMS_FIR_MC_LEAK_EN.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lms_fir_mc
  import lms_fir_pkg::*;
#(
  parameter int TAPS       = 256,
  parameter int CH         = 2,
  parameter int DW         = 16,
  parameter int WW         = 26,
  parameter int LEAK_SHIFT = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     ready,
  input  logic [ch_bits(CH)-1:0]   ch_in,
  input  logic [DW-1:0]            x_in,
  input  logic [DW-1:0]            a_in,
  input  logic [DW-1:0]            mu_err,
  input  logic                     adapt_en,
  output logic [DW-1:0]            y_out,
  output logic                     y_valid,
  output logic [ch_bits(CH)-1:0]   y_ch,
  input  logic [ch_bits(CH)-1:0]   rd_ch,
  input  logic [$clog2(TAPS)-1:0]  rd_tap,
  output logic [WW-1:0]            rd_weight
);

  localparam int CHW   = ch_bits(CH);
  localparam int KW    = $clog2(TAPS);
  localparam int AW    = acc_width(DW, TAPS);
  localparam int NSLOT = CH * TAPS;

  state_e                state_q;
  logic [KW-1:0]         k_q;
  logic [1:0]            drain_q;
  logic [CHW-1:0]        ch_q;
  logic signed [DW-1:0]  mu_q;
  logic                  adapt_q;
  logic                  ready_q;
  logic                  y_valid_q;
  logic [DW-1:0]         y_out_q;
  logic [CHW-1:0]        y_ch_q;

  logic signed [DW-1:0]  x_q [NSLOT];
  logic signed [DW-1:0]  x_d [NSLOT];
  logic signed [WW-1:0]  w_q [NSLOT];
  logic signed [WW-1:0]  w_d [NSLOT];
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [WW-1:0]         rd_weight_q, rd_weight_d;

  logic                  v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
  logic [KW-1:0]         k1_q, k1_d, k2_q, k2_d;
  logic signed [DW-1:0]  x1_q, x1_d, x2_q, x2_d, x3_q, x3_d;
  logic signed [WW-1:0]  w1_q, w1_d, w2_q, w2_d, u2_q, u2_d;
  logic signed [DW-1:0]  wt3_q, wt3_d;
  logic signed [2*DW-1:0] p4_q, p4_d;

  logic                  ch_in_ok, rd_ch_ok, accept;
  logic signed [2*DW-1:0] pu;
  logic signed [DW-1:0]  u_narrow;
  logic signed [WW:0]    w_sum;
  logic signed [WW-1:0]  w_upd, w_new;
  logic signed [AW-1:0]  acc_sh;
  logic signed [DW-1:0]  y_sat;

  if ((1 << CHW) == CH) begin : g_ch_full
    assign ch_in_ok = 1'b1;
    assign rd_ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_in_ok = (ch_in < CHW'(CH));
    assign rd_ch_ok = (rd_ch < CHW'(CH));
  end

  assign accept = (state_q == ST_IDLE) && start && ch_in_ok;

  // u keeps bits [2DW-2:DW-1] of the product; the top bit is dropped, not saturated.
  assign pu       = mu_q * x1_q;
  assign u_narrow = DW'(pu >>> (DW - 1));

`ifdef LMS_FIR_MC_LEAK_EN
  assign w_sum = (WW+1)'(w2_q) - (WW+1)'(w2_q >>> LEAK_SHIFT) + (WW+1)'(u2_q);
`else
  assign w_sum = (WW+1)'(w2_q) + (WW+1)'(u2_q);
`endif

  lms_fir_sat #(.IN_W(WW + 1), .OUT_W(WW)) u_sat_w (.in_val(w_sum), .out_val(w_upd));

  assign w_new  = adapt_q ? w_upd : w2_q;
  assign acc_sh = acc_q >>> (DW - 1);

  lms_fir_sat #(.IN_W(AW), .OUT_W(DW)) u_sat_y (.in_val(acc_sh), .out_val(y_sat));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      drain_q   <= '0;
      ch_q      <= '0;
      mu_q      <= '0;
      adapt_q   <= 1'b0;
      ready_q   <= 1'b1;
      y_valid_q <= 1'b0;
      y_out_q   <= '0;
      y_ch_q    <= '0;
    end else begin
      y_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (accept) begin
          ch_q    <= ch_in;
          mu_q    <= mu_err;
          adapt_q <= adapt_en;
          k_q     <= '0;
          ready_q <= 1'b0;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          k_q <= k_q + KW'(1);
          if (k_q == KW'(TAPS - 1)) begin
            drain_q <= '0;
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          drain_q <= drain_q + 2'd1;
          if (drain_q == 2'(DRAIN_CYCLES - 1)) state_q <= ST_OUT;
        end
        ST_OUT: begin
          y_out_q   <= y_sat;
          y_valid_q <= 1'b1;
          y_ch_q    <= ch_q;
          ready_q   <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    x_d   = x_q;
    w_d   = w_q;
    acc_d = acc_q;
    if (accept) begin
      for (int i = TAPS - 1; i > 0; i--) x_d[{ch_in, KW'(i)}] = x_q[{ch_in, KW'(i - 1)}];
      x_d[{ch_in, KW'(0)}] = x_in;
      acc_d = AW'(signed'(a_in)) <<< (DW - 1);
    end
    if (v2_q) w_d[{ch_q, k2_q}] = w_new;
    if (v4_q) acc_d = acc_q + AW'(p4_q);
    rd_weight_d = rd_ch_ok ? w_q[{rd_ch, rd_tap}] : '0;
  end

  // S1 read, S2 update term, S3 weight write, S4 product, S5 accumulate.
  always_comb begin
    v1_d  = (state_q == ST_RUN);
    k1_d  = k_q;
    x1_d  = x_q[{ch_q, k_q}];
    w1_d  = w_q[{ch_q, k_q}];
    v2_d  = v1_q;
    k2_d  = k1_q;
    x2_d  = x1_q;
    w2_d  = w1_q;
    u2_d  = WW'(u_narrow);
    v3_d  = v2_q;
    x3_d  = x2_q;
    wt3_d = DW'(w_new >>> (WW - DW));
    v4_d  = v3_q;
    p4_d  = wt3_q * x3_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
      acc_q       <= '0;
      rd_weight_q <= '0;
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0; v4_q <= 1'b0;
      k1_q <= '0;   k2_q <= '0;
      x1_q <= '0;   x2_q <= '0;   x3_q <= '0;
      w1_q <= '0;   w2_q <= '0;   u2_q <= '0;
      wt3_q <= '0;  p4_q <= '0;
    end else begin
      x_q         <= x_d;
      w_q         <= w_d;
      acc_q       <= acc_d;
      rd_weight_q <= rd_weight_d;
      v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d; v4_q <= v4_d;
      k1_q <= k1_d; k2_q <= k2_d;
      x1_q <= x1_d; x2_q <= x2_d; x3_q <= x3_d;
      w1_q <= w1_d; w2_q <= w2_d; u2_q <= u2_d;
      wt3_q <= wt3_d; p4_q <= p4_d;
    end
  end

  assign ready     = ready_q;
  assign y_valid   = y_valid_q;
  assign y_out     = y_out_q;
  assign y_ch      = y_ch_q;
  assign rd_weight = rd_weight_q;

endmodule
`default_nettype wire

// File: tb/tb_lms_fir_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lms_fir_mc                                                        |
// | Scoreboard bench for lms_fir_mc against an arithmetic LMS model.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_lms_fir_mc;

  localparam int TAPS = 8;
  localparam int CH   = 3;
  localparam int DW   = 16;
  localparam int WW   = 26;
  localparam int LEAK_SHIFT = 2;
  localparam int LAT  = TAPS + 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        adapt_en = 1'b0;
  logic [1:0]  ch_in = '0;
  logic [1:0]  rd_ch = '0;
  logic [2:0]  rd_tap = '0;
  logic [15:0] x_in = '0, a_in = '0, mu_err = '0;
  logic        ready, y_valid;
  logic [1:0]  y_ch;
  logic [15:0] y_out;
  logic [25:0] rd_weight;

  always #5 clk = ~clk;

  lms_fir_mc #(.TAPS(TAPS), .CH(CH), .DW(DW), .WW(WW), .LEAK_SHIFT(LEAK_SHIFT)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .ch_in(ch_in),
    .x_in(x_in), .a_in(a_in), .mu_err(mu_err), .adapt_en(adapt_en),
    .y_out(y_out), .y_valid(y_valid), .y_ch(y_ch),
    .rd_ch(rd_ch), .rd_tap(rd_tap), .rd_weight(rd_weight)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  longint xm[CH][TAPS];
  longint wm[CH][TAPS];

  typedef struct {
    longint y;
    int     ch;
    int     cyc;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_pass(input int ch, input longint x, input longint a, input longint mu,
                            input bit adapt, output longint y);
    longint acc, p, t, nw;
    for (int k = TAPS - 1; k > 0; k--) xm[ch][k] = xm[ch][k - 1];
    xm[ch][0] = x;
    acc = a * 32768;
    for (int k = 0; k < TAPS; k++) begin
      p = mu * xm[ch][k];
      t = (p >>> 15) & 64'hFFFF;
      if (t >= 32768) t = t - 65536;
      if (adapt) begin
`ifdef LMS_FIR_MC_LEAK_EN
        nw = wm[ch][k] - (wm[ch][k] >>> LEAK_SHIFT) + t;
`else
        nw = wm[ch][k] + t;
`endif
        wm[ch][k] = sat(nw, WW);
      end
      acc = acc + (wm[ch][k] >>> (WW - DW)) * xm[ch][k];
    end
    y = sat(acc >>> 15, DW);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && y_valid) begin
      if (sb.size() == 0) check("unexpected_y_valid", 1, 0);
      else begin
        e = sb.pop_front();
        check("y_out", longint'(y_out), e.y & 64'hFFFF);
        check("y_ch", longint'(y_ch), e.ch);
        check("latency", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input int ch, input logic [15:0] x, input logic [15:0] a,
                       input logic [15:0] mu, input bit adapt, input bit hold);
    int n;
    longint y;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    ch_in = 2'(ch); x_in = x; a_in = a; mu_err = mu; adapt_en = adapt; start = 1'b1;
    @(posedge clk);
    #1;
    model_pass(ch, longint'($signed(x)), longint'($signed(a)), longint'($signed(mu)), adapt, y);
    e.y = y; e.ch = ch; e.cyc = cyc + LAT;
    sb.push_back(e);
    check("ready_busy", longint'(ready), 0);
    if (hold) begin
      repeat (TAPS + 2) begin
        @(negedge clk);
        x_in = 16'($urandom); a_in = 16'($urandom); mu_err = 16'($urandom);
        adapt_en = 1'($urandom_range(0, 1)); ch_in = 2'($urandom_range(0, 3));
      end
    end
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb.size() != 0 || !ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !ready) check("drain_timeout", 0, 1);
  endtask

  task automatic check_weights(input int ch);
    for (int k = 0; k < TAPS; k++) begin
      @(negedge clk);
      rd_ch = 2'(ch); rd_tap = 3'(k);
      @(posedge clk);
      #1;
      check($sformatf("w[%0d][%0d]", ch, k), longint'(rd_weight), wm[ch][k] & ((64'd1 << WW) - 1));
    end
  endtask

  initial begin
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < TAPS; k++) begin
        xm[c][k] = 0;
        wm[c][k] = 0;
      end

    @(posedge clk);
    #1;
    check("rst_ready", longint'(ready), 1);
    check("rst_y_valid", longint'(y_valid), 0);
    check("rst_y_out", longint'(y_out), 0);
    check("rst_y_ch", longint'(y_ch), 0);
    check("rst_rd_weight", longint'(rd_weight), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Frozen pass, then a single adaptive update from zero weights.
    issue(0, 16'h4000, 16'h0000, 16'h4000, 1'b0, 1'b0);
    wait_done();
    check_weights(0);
    issue(0, 16'h4000, 16'h0000, 16'h4000, 1'b1, 1'b0);
    wait_done();
    check_weights(0);

    for (int i = 0; i < 150; i++) begin
      issue($urandom_range(0, CH - 1), 16'($urandom), 16'($urandom),
            ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 511)) - 16'd256,
            1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
      if (i % 25 == 24) begin
        wait_done();
        check_weights($urandom_range(0, CH - 1));
      end
    end

    // The one product whose top bit is discarded.
    issue(1, 16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++)
      issue(1, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1, $urandom_range(0, 1) == 1);
    wait_done();
    check_weights(0);
    check_weights(1);
    check_weights(2);

    // Drive channel 2 into positive weight and output saturation.
    for (int i = 0; i < 1100; i++)
      issue(2, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
    wait_done();
    check_weights(2);
    check("w_sat_max", wm[2][0], (longint'(1) << (WW - 1)) - 1);

    @(negedge clk);
    ch_in = 2'd3; start = 1'b1;
    @(posedge clk);
    #1;
    check("bad_ch_ready", longint'(ready), 1);
    start = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    check("bad_ch_ready_later", longint'(ready), 1);

    @(negedge clk);
    rd_ch = 2'd3; rd_tap = 3'd0;
    @(posedge clk);
    #1;
    check("rd_bad_ch", longint'(rd_weight), 0);

    // Reset in the middle of a pass.
    issue(1, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < TAPS; k++) begin
        xm[c][k] = 0;
        wm[c][k] = 0;
      end
    #1;
    check("mid_rst_ready", longint'(ready), 1);
    check("mid_rst_y_valid", longint'(y_valid), 0);
    check("mid_rst_y_out", longint'(y_out), 0);
    check("mid_rst_rd_weight", longint'(rd_weight), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (LAT) @(negedge clk);
    for (int c = 0; c < CH; c++) check_weights(c);

    issue(0, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b0);
    wait_done();
    check_weights(0);
    check("sb_empty", longint'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
